// File: rtl/bcd_addsub_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bcd_addsub_serial
//  Purpose  : Digit-serial packed-BCD adder/subtractor, LSD first, with
//             sign-magnitude output for negative differences.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_addsub_serial #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  sign,
    output logic                  overflow,
    output logic                  invalid
);

    localparam int IDX_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [DIGITS-1:0][3:0] r_x;
    logic [DIGITS-1:0][3:0] r_y;
    logic [DIGITS-1:0][3:0] r_res;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_mode;
    logic                   r_carry;
    logic                   r_sign;
    logic                   r_ovf;
    logic                   r_inv;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_bad;
    logic                   w_last;
    logic                   w_cout;
    logic [3:0]             w_xd;
    logic [3:0]             w_yd;
    logic [3:0]             w_rd;
    logic [3:0]             w_addend;
    logic [3:0]             w_adj;
    logic [3:0]             w_digit;
    logic [4:0]             w_sum;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((x[4*i +: 4] > 4'd9) || (y[4*i +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end

    always_comb begin
        w_xd = '0;
        w_yd = '0;
        w_rd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_xd = r_x[i];
                w_yd = r_y[i];
                w_rd = r_res[i];
            end
        end
    end

    // One decimal digit slice shared by the CALC and FIX passes.
    always_comb begin
        w_addend = r_mode ? (4'd9 - w_xd) : w_xd;
        if (r_state == S_FIX) begin
            w_sum = {1'b0, 4'd9 - w_rd} + {4'd0, r_carry};
        end else begin
            w_sum = {1'b0, w_yd} + {1'b0, w_addend} + {4'd0, r_carry};
        end
        w_cout  = (w_sum > 5'd9);
        w_adj   = w_sum[3:0] - 4'd10;
        w_digit = w_cout ? w_adj : w_sum[3:0];
        w_last  = (r_idx == IDX_W'(DIGITS - 1));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = w_bad ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_next = (r_mode && !w_cout) ? S_FIX : S_DONE;
            S_FIX:   if (w_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_res   <= '0;
            r_idx   <= '0;
            r_mode  <= 1'b0;
            r_carry <= 1'b0;
            r_sign  <= 1'b0;
            r_ovf   <= 1'b0;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    // busy is still high during the done cycle and drops here
                    r_busy <= start;
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_mode  <= mode;
                        r_idx   <= '0;
                        r_carry <= mode;
                        r_res   <= '0;
                        r_sign  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_inv   <= w_bad;
                    end
                end
                S_CALC, S_FIX: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_res[i] <= w_digit;
                        end
                    end
                    r_carry <= w_cout;
                    r_idx   <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        // The complement pass always begins with +1.
                        r_carry <= 1'b1;
                        if (r_state == S_CALC) begin
                            if (!r_mode) begin
                                r_ovf <= w_cout;
                            end else if (!w_cout) begin
                                r_sign <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_res;
    assign sign     = r_sign;
    assign overflow = r_ovf;
    assign invalid  = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_bcd_addsub_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_addsub_serial
//  Purpose  : Self-checking bench for bcd_addsub_serial at DIGITS = 2, 3, 5
//             against an integer-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_addsub_serial;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        start2, mode2, busy2, done2, sign2, ovf2, inv2;
    logic [7:0]  x2, y2, res2;
    logic        start3, mode3, busy3, done3, sign3, ovf3, inv3;
    logic [11:0] x3, y3, res3;
    logic        start5, mode5, busy5, done5, sign5, ovf5, inv5;
    logic [19:0] x5, y5, res5;

    bcd_addsub_serial #(.DIGITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .mode(mode2), .x(x2), .y(y2),
        .busy(busy2), .done(done2), .result(res2), .sign(sign2), .overflow(ovf2), .invalid(inv2));
    bcd_addsub_serial #(.DIGITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .mode(mode3), .x(x3), .y(y3),
        .busy(busy3), .done(done3), .result(res3), .sign(sign3), .overflow(ovf3), .invalid(inv3));
    bcd_addsub_serial #(.DIGITS(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .mode(mode5), .x(x5), .y(y5),
        .busy(busy5), .done(done5), .result(res5), .sign(sign5), .overflow(ovf5), .invalid(inv5));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [19:0] res;
        logic        sgn;
        logic        ovf;
        logic        inv;
        logic [7:0]  lat;
    } outcome_t;

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic int pow10(int d);
        int p = 1;
        for (int i = 0; i < d; i++) p *= 10;
        return p;
    endfunction

    function automatic int bcd_val(logic [19:0] v, int d);
        int r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [19:0] to_bcd(int n, int d);
        logic [19:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(logic [19:0] v, int d);
        for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic outcome_t model(int d, bit m, logic [19:0] yv, logic [19:0] xv);
        outcome_t o = '0;
        int a, b, lim;
        if (has_bad(yv, d) || has_bad(xv, d)) begin
            o.inv = 1'b1;
            o.lat = 8'd1;
            return o;
        end
        a = bcd_val(yv, d);
        b = bcd_val(xv, d);
        lim = pow10(d);
        o.lat = 8'(d + 1);
        if (!m) begin
            o.ovf = ((a + b) >= lim);
            o.res = to_bcd((a + b) % lim, d);
        end else if (a >= b) begin
            o.res = to_bcd(a - b, d);
        end else begin
            o.sgn = 1'b1;
            o.res = to_bcd(b - a, d);
            o.lat = 8'(2 * d + 1);
        end
        return o;
    endfunction

    // ---------------- DUT access by width ----------------
    task automatic drive(int d, bit st, bit m, logic [19:0] yv, logic [19:0] xv);
        case (d)
            2:       begin start2 = st; mode2 = m; y2 = yv[7:0];  x2 = xv[7:0];  end
            3:       begin start3 = st; mode3 = m; y3 = yv[11:0]; x3 = xv[11:0]; end
            default: begin start5 = st; mode5 = m; y5 = yv;       x5 = xv;       end
        endcase
    endtask

    function automatic outcome_t observe(int d);
        outcome_t o = '0;
        case (d)
            2:       begin o.res = {12'd0, res2}; o.sgn = sign2; o.ovf = ovf2; o.inv = inv2; end
            3:       begin o.res = {8'd0, res3};  o.sgn = sign3; o.ovf = ovf3; o.inv = inv3; end
            default: begin o.res = res5;          o.sgn = sign5; o.ovf = ovf5; o.inv = inv5; end
        endcase
        return o;
    endfunction

    function automatic logic get_done(int d);
        return (d == 2) ? done2 : (d == 3) ? done3 : done5;
    endfunction

    function automatic logic get_busy(int d);
        return (d == 2) ? busy2 : (d == 3) ? busy3 : busy5;
    endfunction

    // Entered #1 after an edge with the DUT idle; returns #1 after an edge.
    task automatic run_op(input int d, input bit m, input logic [19:0] yv, input logic [19:0] xv,
                          output outcome_t got, output outcome_t held, output int nd,
                          output logic b0, output logic bend);
        drive(d, 1'b1, m, yv, xv);
        @(posedge clk); #1;
        b0 = get_busy(d);
        drive(d, 1'b0, !m, 20'($urandom), 20'($urandom));
        got = '0;
        nd  = 0;
        for (int k = 1; k <= 2 * d + 4; k++) begin
            @(posedge clk); #1;
            if (get_done(d) === 1'b1) begin
                if (nd == 0) begin
                    got = observe(d);
                    got.lat = 8'(k);
                end
                nd++;
            end
        end
        held = observe(d);
        held.lat = got.lat;
        bend = get_busy(d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int nd = 0;
        reset_n = 1'b0;
        drive(2, 1'b1, 1'b0, 20'h12, 20'h34);
        drive(3, 1'b1, 1'b1, 20'h523, 20'h123);
        drive(5, 1'b1, 1'b0, 20'h12345, 20'h54321);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (done2 === 1'b1 || done3 === 1'b1 || done5 === 1'b1) nd++;
            n_cmp++;
            if ({busy2, done2, busy3, done3, busy5, done5} !== 6'd0 ||
                observe(2) !== '0 || observe(3) !== '0 || observe(5) !== '0) begin
                n_bad++;
                $display("FAIL reset_state c%0d: busy=%b%b%b done=%b%b%b res3=%h flags3=%b%b%b, want all 0",
                         c, busy2, busy3, busy5, done2, done3, done5, res3, sign3, ovf3, inv3);
            end
        end
        drive(2, 1'b0, 1'b0, '0, '0);
        drive(3, 1'b0, 1'b0, '0, '0);
        drive(5, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        if (done2 === 1'b1 || done3 === 1'b1 || done5 === 1'b1 || busy3 !== 1'b0) nd++;
        n_cmp++;
        if (nd != 0) begin
            n_bad++;
            $display("FAIL reset_no_done: activity count=%0d, want 0", nd);
        end
    endtask

    task automatic test_directed();
        int          td[7] = '{3, 3, 3, 3, 3, 3, 5};
        bit          tm[7] = '{1, 1, 0, 0, 1, 1, 1};
        logic [19:0] ty[7] = '{20'h523, 20'h123, 20'h999, 20'h456, 20'h777, 20'h123, 20'h00123};
        logic [19:0] tx[7] = '{20'h123, 20'h523, 20'h001, 20'h321, 20'h777, 20'h1A3, 20'h98765};
        logic [19:0] tr[7] = '{20'h400, 20'h400, 20'h000, 20'h777, 20'h000, 20'h000, 20'h98642};
        bit          ts[7] = '{0, 1, 0, 0, 0, 0, 1};
        bit          tv[7] = '{0, 0, 1, 0, 0, 0, 0};
        bit          ti[7] = '{0, 0, 0, 0, 0, 1, 0};
        int          tl[7] = '{4, 7, 4, 4, 4, 1, 11};
        outcome_t e, got, held;
        int nd;
        logic b0, bend;
        for (int i = 0; i < 7; i++) begin
            e = '{res: tr[i], sgn: ts[i], ovf: tv[i], inv: ti[i], lat: 8'(tl[i])};
            run_op(td[i], tm[i], ty[i], tx[i], got, held, nd, b0, bend);
            n_cmp++;
            if (got !== e || held !== e || nd != 1 || b0 !== 1'b1 || bend !== 1'b0) begin
                n_bad++;
                $display("FAIL directed[%0d]: res=%h s=%b o=%b i=%b lat=%0d dones=%0d busy0=%b busy_end=%b held=%h | want res=%h s=%b o=%b i=%b lat=%0d dones=1",
                         i, got.res, got.sgn, got.ovf, got.inv, got.lat, nd, b0, bend, held.res,
                         e.res, e.sgn, e.ovf, e.inv, e.lat);
            end
        end
    endtask

    task automatic test_random();
        outcome_t e, got, held;
        int nd, d, j;
        logic b0, bend;
        bit m;
        logic [19:0] yv, xv;
        for (int n = 0; n < 40; n++) begin
            d  = (n % 3 == 0) ? 5 : 3;
            m  = 1'($urandom_range(0, 1));
            yv = '0;
            xv = '0;
            for (int i = 0; i < d; i++) begin
                yv[4*i +: 4] = 4'($urandom_range(0, 9));
                xv[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) begin
                j = $urandom_range(0, d - 1);
                if ($urandom_range(0, 1) == 0) xv[4*j +: 4] = 4'($urandom_range(10, 15));
                else                           yv[4*j +: 4] = 4'($urandom_range(10, 15));
            end
            e = model(d, m, yv, xv);
            run_op(d, m, yv, xv, got, held, nd, b0, bend);
            n_cmp++;
            if (got !== e || held !== e || nd != 1 || b0 !== 1'b1 || bend !== 1'b0) begin
                n_bad++;
                $display("FAIL random[%0d] d=%0d m=%b y=%h x=%h: res=%h s=%b o=%b i=%b lat=%0d dones=%0d busy0=%b busy_end=%b | want res=%h s=%b o=%b i=%b lat=%0d",
                         n, d, m, yv, xv, got.res, got.sgn, got.ovf, got.inv, got.lat, nd, b0, bend,
                         e.res, e.sgn, e.ovf, e.inv, e.lat);
            end
        end
    endtask

    task automatic test_ignore_start();
        int t_done = -1;
        int nd = 0;
        logic [11:0] r = '0;
        logic s = 1'b0;
        drive(3, 1'b1, 1'b1, 20'h523, 20'h123);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b1, 20'h523, 20'h123);
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) drive(3, 1'b1, 1'b0, 20'h999, 20'h001);
            @(posedge clk); #1;
            if (k == 2) drive(3, 1'b0, 1'b0, 20'h999, 20'h001);
            if (done3 === 1'b1) begin
                nd++;
                if (t_done < 0) begin
                    t_done = k;
                    r = res3;
                    s = sign3;
                end
            end
        end
        n_cmp++;
        if (nd != 1 || t_done != 4 || r !== 12'h400 || s !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_start: dones=%0d at=%0d res=%h sign=%b, want dones=1 at=4 res=400 sign=0",
                     nd, t_done, r, s);
        end
    endtask

    task automatic test_reset_abort();
        int nd = 0;
        outcome_t e, got, held;
        logic b0, bend;
        drive(3, 1'b1, 1'b1, 20'h123, 20'h523);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b1, 20'h123, 20'h523);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_cmp++;
        if ({busy3, done3, sign3, ovf3, inv3} !== 5'd0 || res3 !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_abort_state: busy=%b done=%b res=%h s=%b o=%b i=%b, want all 0",
                     busy3, done3, res3, sign3, ovf3, inv3);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done3 === 1'b1 || busy3 !== 1'b0) nd++;
        end
        n_cmp++;
        if (nd != 0) begin
            n_bad++;
            $display("FAIL reset_abort_quiet: busy/done seen %0d times, want 0", nd);
        end
        e = '{res: 20'h777, sgn: 1'b0, ovf: 1'b0, inv: 1'b0, lat: 8'd4};
        run_op(3, 1'b0, 20'h456, 20'h321, got, held, nd, b0, bend);
        n_cmp++;
        if (got !== e || nd != 1) begin
            n_bad++;
            $display("FAIL reset_abort_restart: res=%h lat=%0d dones=%0d, want res=777 lat=4 dones=1",
                     got.res, got.lat, nd);
        end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1, extra = 0;
        logic [11:0] r1 = '0, r2 = '0;
        logic s1 = 1'b0, busy_gap = 1'b0;
        drive(3, 1'b1, 1'b1, 20'h523, 20'h123);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, 20'h0, 20'h0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (t1 >= 0 && k == t1 + 1) drive(3, 1'b0, 1'b1, 20'h0, 20'h0);
            if (t2 < 0 && busy3 !== 1'b1) busy_gap = 1'b1;
            if (done3 === 1'b1) begin
                if (t1 < 0) begin
                    t1 = k;
                    r1 = res3;
                    s1 = sign3;
                    // second start sampled on the very next edge (first IDLE cycle)
                    drive(3, 1'b1, 1'b0, 20'h456, 20'h321);
                end else if (t2 < 0) begin
                    t2 = k;
                    r2 = res3;
                end else begin
                    extra++;
                end
            end
        end
        n_cmp++;
        if (t1 != 4 || r1 !== 12'h400 || s1 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first: at=%0d res=%h sign=%b, want at=4 res=400 sign=0", t1, r1, s1);
        end
        n_cmp++;
        if (t2 != t1 + 1 + 4 || r2 !== 12'h777 || extra != 0 || busy_gap !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second: at=%0d res=%h extra=%0d busy_gap=%b, want at=%0d res=777 extra=0 busy_gap=0",
                     t2, r2, extra, busy_gap, t1 + 5);
        end
    endtask

    task automatic test_exhaustive_d2();
        outcome_t e, got;
        int k;
        for (int a = 0; a < 100; a++) begin
            for (int b = 0; b < 100; b++) begin
                drive(2, 1'b1, 1'b1, to_bcd(a, 2), to_bcd(b, 2));
                @(posedge clk); #1;
                drive(2, 1'b0, 1'b0, 20'($urandom), 20'($urandom));
                k = 0;
                while (done2 !== 1'b1 && k < 12) begin
                    @(posedge clk); #1;
                    k++;
                end
                got = observe(2);
                got.lat = 8'(k);
                e = model(2, 1'b1, to_bcd(a, 2), to_bcd(b, 2));
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL exh_d2 %0d-%0d: res=%h s=%b o=%b lat=%0d | want res=%h s=%b o=%b lat=%0d",
                             a, b, got.res, got.sgn, got.ovf, got.lat, e.res, e.sgn, e.ovf, e.lat);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_exhaustive_d2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
